// File: rtl/fmul_arbiter.sv
// Round-robin arbiter that shares one combinational FP32 multiplier among
// N_REQ requesters. Operands are registered in stage 1 and products in stage 2.
// The result register carries the ID of the requester that issued the operation.

// Combinational IEEE-754 single-precision multiplier.
// Rounds to nearest, ties to even. Subnormal inputs and underflowing results
// are flushed to signed zero. Invalid operations return the canonical quiet NaN.
module fmul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] c_o
);

  logic        sign;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic [22:0] mant;
  logic        guard, sticky, round_up;
  logic [23:0] mant_r;
  logic [9:0]  e_sum;

  assign sign   = a_i[31] ^ b_i[31];
  assign ea     = a_i[30:23];
  assign eb     = b_i[30:23];
  assign fa     = a_i[22:0];
  assign fb     = b_i[22:0];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign prod   = 48'({1'b1, fa}) * 48'({1'b1, fb});

  // Normalise, round and pack; special operands override the normal path.
  always_comb begin
    c_o = '0;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'b0, round_up};
    // Biased exponent sum plus 127; rounding carry bumps the exponent and
    // leaves mant_r[22:0] at zero, which is the correct fraction.
    e_sum    = {2'b0, ea} + {2'b0, eb} + {9'b0, prod[47]} + {9'b0, mant_r[23]};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      c_o = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      c_o = {sign, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      c_o = {sign, 31'b0};
    end else if (e_sum >= 10'd382) begin
      c_o = {sign, 8'hFF, 23'b0};
    end else if (e_sum <= 10'd127) begin
      c_o = {sign, 31'b0};
    end else begin
      c_o = {sign, 8'(e_sum - 10'd127), mant_r[22:0]};
    end
  end

endmodule

module fmul_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        res_valid_o,
  output logic [DATA_WIDTH-1:0]       res_data_o,
  output logic [ID_W-1:0]             res_id_o,
  input  logic                        res_ready_i,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            op_count_o
);

  localparam int unsigned NR = N_REQ;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic [ID_W-1:0]       s1_id;
  logic [ID_W-1:0]       rr_ptr;

  logic                  s1_adv, s2_adv;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       ptr_next;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [DATA_WIDTH-1:0] mul_c;
  int unsigned           rr_idx;

  assign s2_adv = !res_valid_o || res_ready_i;
  assign s1_adv = !s1_valid || s2_adv;
  assign busy_o = s1_valid || res_valid_o;

  // Round-robin search over req_valid_i starting at the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      rr_idx = (32'(rr_ptr) + i) % NR;
      if (!grant_any && req_valid_i[ID_W'(rr_idx)]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(rr_idx);
      end
    end
  end

  assign accept   = s1_adv && grant_any;
  assign ptr_next = (grant_id == ID_W'(NR - 1)) ? '0 : ID_W'(grant_id + 1'b1);

  // Drive a single ready bit for the winner, only while stage 1 can take it.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  // Operand multiplexer for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (grant_id == ID_W'(k)) begin
        sel_a = req_a_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  fmul u_fmul (
    .a_i (s1_a),
    .b_i (s1_b),
    .c_o (mul_c)
  );

  // Stage 1 operand register and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= sel_a;
        s1_b   <= sel_b;
        s1_id  <= grant_id;
        rr_ptr <= ptr_next;
      end
    end
  end

  // Stage 2 result register; data and ID hold when a bubble moves in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_id_o    <= '0;
    end else if (s2_adv) begin
      res_valid_o <= s1_valid;
      if (s1_valid) begin
        res_data_o <= mul_c;
        res_id_o   <= s1_id;
      end
    end
  end

  // Count completed result handshakes, wrapping naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_count_o <= '0;
    end else if (res_valid_o && res_ready_i) begin
      op_count_o <= op_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: a cycle model of the arbiter and
// pipeline occupancy plus a scoreboard of expected products in accept order.
module tb_fmul_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int NV = 12;

  localparam logic [31:0] VA [NV] = '{
    32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h00000000,
    32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3F800001,
    32'h3FFFFFFF, 32'h7F000000, 32'h7F800000, 32'h3F800001};
  localparam logic [31:0] VB [NV] = '{
    32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
    32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3FC00000,
    32'h3FFFFFFF, 32'h40000000, 32'hC0000000, 32'h3F800001};
  localparam logic [31:0] VP [NV] = '{
    32'h40000000, 32'h40400000, 32'hC0000000, 32'h00000000,
    32'h3F800000, 32'h41100000, 32'h40100000, 32'h3FC00002,
    32'h407FFFFE, 32'h7F800000, 32'hFF800000, 32'h3F800002};

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR*DW-1:0]  req_a_i;
  logic [NR*DW-1:0]  req_b_i;
  logic [NR-1:0]     req_ready_o;
  logic              res_valid_o;
  logic [DW-1:0]     res_data_o;
  logic [IW-1:0]     res_id_o;
  logic              res_ready_i;
  logic              busy_o;
  logic [CW-1:0]     op_count_o;

  int vsel [NR];

  always #5 clk = ~clk;

  fmul_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (NR),
    .ID_W       (IW),
    .CNT_W      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_ready_o (req_ready_o),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_id_o    (res_id_o),
    .res_ready_i (res_ready_i),
    .busy_o      (busy_o),
    .op_count_o  (op_count_o)
  );

  always_comb begin
    req_a_i = '0;
    req_b_i = '0;
    for (int k = 0; k < NR; k++) begin
      req_a_i[k*DW +: DW] = VA[vsel[k]];
      req_b_i[k*DW +: DW] = VB[vsel[k]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   p;
  } sb_t;

  sb_t           sb [$];
  logic          m_s1, m_s2;
  logic [IW-1:0] m_ptr;
  logic [CW-1:0] m_cnt;
  int            n_acc = 0;
  logic [NR-1:0] s_valid, exp_rdy;
  logic          s_rr, m_s1_adv, m_s2_adv;

  function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input logic [IW-1:0] p);
    logic [NR-1:0] g;
    g = '0;
    for (int i = 0; i < NR; i++) begin
      int j;
      j = (int'(p) + i) % NR;
      if (v[j] && g == '0) g[j] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_s1  = 1'b0;
    m_s2  = 1'b0;
    m_ptr = '0;
    m_cnt = '0;
  endtask

  // Reference model: checks outputs mid-cycle, advances state on the edge.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (rst_i) begin
        model_clear();
        exp_rdy = '0;
      end else begin
        s_valid  = req_valid_i;
        s_rr     = res_ready_i;
        m_s1_adv = !m_s1 || !m_s2 || s_rr;
        exp_rdy  = m_s1_adv ? rr_pick(s_valid, m_ptr) : '0;
        check("ready", req_ready_o, exp_rdy);
        check("res_valid", res_valid_o, m_s2);
        check("busy", busy_o, m_s1 | m_s2);
        check("op_count", op_count_o, m_cnt);
        if (m_s2) begin
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
          end else begin
            check("res_data", res_data_o, sb[0].p);
            check("res_id", res_id_o, sb[0].id);
          end
        end
      end
      @(posedge clk);
      if (rst_i) begin
        model_clear();
      end else begin
        m_s2_adv = !m_s2 || s_rr;
        if (m_s2 && s_rr) begin
          if (sb.size() > 0) void'(sb.pop_front());
          m_cnt = m_cnt + 1'b1;
        end
        if (m_s2_adv) m_s2 = m_s1;
        if (m_s1_adv) m_s1 = (exp_rdy != '0);
        for (int k = 0; k < NR; k++) begin
          if (exp_rdy[k]) begin
            sb.push_back('{id: IW'(k), p: VP[vsel[k]]});
            m_ptr = IW'((k + 1) % NR);
            n_acc++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    req_valid_i = '0;
    res_ready_i = 1'b1;
    budget = 0;
    while ((busy_o || sb.size() != 0) && budget < 20) begin
      step(1);
      budget++;
    end
    if (budget >= 20) check("drain_timeout", busy_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    int a0;
    rst_i       = 1'b1;
    req_valid_i = '0;
    res_ready_i = 1'b1;
    for (int k = 0; k < NR; k++) vsel[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_data", res_data_o, 0);
    check("rst_res_id", res_id_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_count", op_count_o, 0);
    rst_i = 1'b0;

    // Single operation from requester 0.
    vsel[0] = 0;
    req_valid_i = 4'b0001;
    #1 check("t1_ready", req_ready_o, 4'b0001);
    step(1);
    req_valid_i = '0;
    drain();
    check("t1_count", op_count_o, 1);

    // Three requesters together: grants 0,1,2 back to back.
    do_reset();
    vsel[0] = 1; vsel[1] = 2; vsel[2] = 3;
    req_valid_i = 4'b0111;
    step(3);
    req_valid_i = '0;
    drain();
    check("t2_count", op_count_o, 3);

    // Requesters 0 and 3 contending must alternate.
    vsel[0] = 5; vsel[3] = 6;
    a0 = n_acc;
    req_valid_i = 4'b1001;
    step(8);
    req_valid_i = '0;
    check("t3_accepts", n_acc - a0, 8);
    drain();

    // Backpressure: only two operations fit while the consumer stalls.
    do_reset();
    vsel[1] = 4;
    res_ready_i = 1'b0;
    req_valid_i = 4'b0010;
    a0 = n_acc;
    step(4);
    check("t4_accepts", n_acc - a0, 2);
    check("t4_stall_ready", req_ready_o, 0);
    check("t4_hold_data", res_data_o, 32'h3F800000);
    check("t4_hold_id", res_id_o, 1);
    res_ready_i = 1'b1;
    req_valid_i = '0;
    drain();
    check("t4_count", op_count_o, 2);

    // Asynchronous reset with both stages full.
    vsel[0] = 5; vsel[1] = 6; vsel[2] = 7; vsel[3] = 8;
    req_valid_i = 4'b1111;
    res_ready_i = 1'b0;
    step(3);
    @(posedge clk);
    #3 rst_i = 1'b1;
    #1;
    check("t5_res_valid", res_valid_o, 0);
    check("t5_res_data", res_data_o, 0);
    check("t5_res_id", res_id_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_count", op_count_o, 0);
    req_valid_i = 4'b1001;
    res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    #1 check("t5_ptr_reset", req_ready_o, 4'b0001);
    step(1);
    req_valid_i = '0;
    drain();
    check("t5_count_after", op_count_o, 1);

    // Counter wrap: 17 handshakes on a 4-bit counter.
    do_reset();
    for (int k = 0; k < NR; k++) vsel[k] = $urandom_range(0, NV - 1);
    a0 = n_acc;
    req_valid_i = 4'b1111;
    step(17);
    req_valid_i = '0;
    check("t6_accepts", n_acc - a0, 17);
    drain();
    check("t6_count_wrap", op_count_o, 1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      req_valid_i = NR'($urandom);
      res_ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NR; k++) vsel[k] = $urandom_range(0, NV - 1);
      step(1);
    end
    drain();
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
